// File: rtl/effect_controller.sv
// Hands one audio sample at a time to the effect modules, collects the result chosen
// by the per-sample effect select, and forwards it downstream with a bypass fallback.
module effect_controller #(
    parameter int d_width = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                sw,
    input  logic                      i_in_valid,
    input  logic signed [d_width-1:0] i_in_data,
    output logic                      o_in_ready,
    output logic                      o_data_ready,
    output logic signed [d_width-1:0] o_data,
    output logic                      o_read_done,
    input  logic                      i_read_enable,
    input  logic                      i_data_valid,
    input  logic signed [d_width-1:0] i_data_sw0,
    input  logic signed [d_width-1:0] i_data_sw1,
    output logic                      o_out_valid,
    output logic signed [d_width-1:0] o_out_data,
    input  logic                      i_out_ready,
    output logic                      o_timeout_err,
    output logic [15:0]               o_sample_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last WAIT count without a result; the next idle edge makes the counter reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        OFFER,
        DONE,
        WAIT,
        OUT
    } state_t;

    state_t                      r_state;
    logic signed [d_width-1:0]   r_sample;
    logic signed [d_width-1:0]   r_out_data;
    logic [1:0]                  r_sel;
    logic [CNT_W-1:0]            r_wait_cnt;
    logic                        r_in_ready;
    logic                        r_data_ready;
    logic                        r_read_done;
    logic                        r_out_valid;
    logic                        r_timeout_err;
    logic [15:0]                 r_sample_count;
    logic signed [d_width-1:0]   w_result;

    function automatic logic signed [d_width-1:0] select_result(
        input logic [1:0]                sel,
        input logic signed [d_width-1:0] raw,
        input logic signed [d_width-1:0] res_sw0,
        input logic signed [d_width-1:0] res_sw1
    );
        case (sel)
            2'b00:   return raw;
            2'b01:   return res_sw0;
            default: return res_sw1;
        endcase
    endfunction

    assign w_result = select_result(r_sel, r_sample, i_data_sw0, i_data_sw1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_sample       <= '0;
            r_out_data     <= '0;
            r_sel          <= 2'b00;
            r_wait_cnt     <= '0;
            r_in_ready     <= 1'b1;
            r_data_ready   <= 1'b0;
            r_read_done    <= 1'b0;
            r_out_valid    <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_sample_count <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_sample     <= i_in_data;
                        r_sel        <= sw;
                        r_in_ready   <= 1'b0;
                        r_data_ready <= 1'b1;
                        r_state      <= OFFER;
                    end
                end
                OFFER: begin
                    if (i_read_enable) begin
                        r_data_ready <= 1'b0;
                        r_read_done  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_read_done <= 1'b0;
                    r_wait_cnt  <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the timeout cycle takes priority over the bypass.
                    if (i_data_valid) begin
                        r_out_data  <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == CNT_LAST) begin
                            r_out_data    <= r_sample;
                            r_timeout_err <= 1'b1;
                            r_out_valid   <= 1'b1;
                            r_state       <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (i_out_ready) begin
                        r_out_valid    <= 1'b0;
                        r_in_ready     <= 1'b1;
                        r_sample_count <= r_sample_count + 16'h0001;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_data_ready <= 1'b0;
                    r_read_done  <= 1'b0;
                    r_out_valid  <= 1'b0;
                    r_in_ready   <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_data_ready   = r_data_ready;
    assign o_data         = r_sample;
    assign o_read_done    = r_read_done;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_out_data;
    assign o_timeout_err  = r_timeout_err;
    assign o_sample_count = r_sample_count;

endmodule

// File: tb/tb_effect_controller.sv
// Directed bench for effect_controller: expected outputs are queued at issue time and
// a negedge monitor pops them on each downstream handshake.
module tb_effect_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sw;
    logic        i_in_valid;
    logic [15:0] i_in_data;
    logic        o_in_ready;
    logic        o_data_ready;
    logic [15:0] o_data;
    logic        o_read_done;
    logic        i_read_enable;
    logic        i_data_valid;
    logic [15:0] i_data_sw0;
    logic [15:0] i_data_sw1;
    logic        o_out_valid;
    logic [15:0] o_out_data;
    logic        i_out_ready;
    logic        o_timeout_err;
    logic [15:0] o_sample_count;

    int n_total = 0;
    int n_pass  = 0;
    logic [15:0] exp_q[$];

    effect_controller #(.d_width(16), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .sw(sw),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_data_ready(o_data_ready), .o_data(o_data), .o_read_done(o_read_done),
        .i_read_enable(i_read_enable), .i_data_valid(i_data_valid),
        .i_data_sw0(i_data_sw0), .i_data_sw1(i_data_sw1),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
        .o_timeout_err(o_timeout_err), .o_sample_count(o_sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: a handshake happens on the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!reset && o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {16'h0, o_out_data}, 32'hFFFF_FFFF);
            end else begin
                check("out_data", {16'h0, o_out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the capture edge, i.e. early in the OFFER cycle.
    task automatic send(input logic [1:0] s, input logic [15:0] d, input logic [15:0] e,
                        input bit push);
        bit ok = 0;
        step();
        sw = s;
        i_in_data = d;
        i_in_valid = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (o_in_ready) begin ok = 1; break; end
        end
        if (!ok) check("wait_in_ready", 32'd0, 32'd1);
        if (push) exp_q.push_back(e);
        step();
        i_in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        bit ok = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (o_out_valid) begin ok = 1; break; end
        end
        if (!ok) check("wait_out_valid", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit stable;
        reset = 1'b1; sw = 2'b00; i_in_valid = 1'b0; i_in_data = 16'h0;
        i_read_enable = 1'b1; i_data_valid = 1'b1; i_out_ready = 1'b1;
        i_data_sw0 = 16'h0; i_data_sw1 = 16'h0;

        repeat (2) @(negedge clk);
        check("rst_in_ready",   {31'h0, o_in_ready}, 32'd1);
        check("rst_data_ready", {31'h0, o_data_ready}, 32'd0);
        check("rst_read_done",  {31'h0, o_read_done}, 32'd0);
        check("rst_out_valid",  {31'h0, o_out_valid}, 32'd0);
        check("rst_data",       {o_data, o_out_data}, 32'd0);
        check("rst_timeout",    {31'h0, o_timeout_err}, 32'd0);
        check("rst_count",      {16'h0, o_sample_count}, 32'd0);
        step();
        reset = 1'b0;

        // Minimum-latency pass-through with sw=01
        i_data_sw0 = 16'h1234; i_data_sw1 = 16'hBEEF;
        send(2'b01, 16'h1234, 16'h1234, 1);
        @(negedge clk);
        check("lat_offer", {14'h0, o_data_ready, o_read_done, o_data}, {16'h2, 16'h1234});
        @(negedge clk);
        check("lat_done", {30'h0, o_data_ready, o_read_done}, 32'd1);
        @(negedge clk);
        check("lat_wait", {30'h0, o_read_done, o_out_valid}, 32'd0);
        @(negedge clk);
        check("lat_out", {31'h0, o_out_valid}, 32'd1);
        @(negedge clk);
        check("count_1", {15'h0, o_in_ready, o_sample_count}, {16'h1, 16'h1});

        // Selection by latched sw
        i_data_sw0 = 16'h2222; i_data_sw1 = 16'h3333;
        send(2'b01, 16'h1111, 16'h2222, 1); wait_out_valid();
        send(2'b00, 16'h8001, 16'h8001, 1); wait_out_valid();
        send(2'b11, 16'h0005, 16'h3333, 1); wait_out_valid();

        // sw=10 with sw changed during WAIT
        i_data_valid = 1'b0; i_data_sw0 = 16'h1111; i_data_sw1 = 16'h00F0;
        send(2'b10, 16'h7FFF, 16'h00F0, 1);
        repeat (4) step();
        sw = 2'b01; i_data_sw0 = 16'h0BAD;
        step();
        i_data_valid = 1'b1;
        wait_out_valid();
        check("hold_o_data", {16'h0, o_data}, 32'h7FFF);

        // Result arrives on the very cycle the counter reaches TIMEOUT
        i_data_valid = 1'b0; i_data_sw0 = 16'h2468;
        send(2'b01, 16'h1357, 16'h2468, 1);
        repeat (256) step();
        i_data_valid = 1'b1;
        @(negedge clk);
        check("race_wait", {31'h0, o_out_valid}, 32'd0);
        @(negedge clk);
        check("race_out", {30'h0, o_out_valid, o_timeout_err}, 32'd2);

        // Timeout bypass after 255 WAIT cycles
        i_data_valid = 1'b0; i_data_sw0 = 16'h1111;
        send(2'b01, 16'h4321, 16'h4321, 1);
        repeat (256) step();
        @(negedge clk);
        check("to_before", {30'h0, o_out_valid, o_timeout_err}, 32'd0);
        @(negedge clk);
        check("to_fire", {30'h0, o_out_valid, o_timeout_err}, 32'd3);
        i_data_valid = 1'b1; i_data_sw0 = 16'h6666;
        send(2'b01, 16'h0001, 16'h6666, 1);
        wait_out_valid();
        check("to_sticky", {31'h0, o_timeout_err}, 32'd1);

        // Back-pressure on both handshakes
        i_read_enable = 1'b0; i_data_sw0 = 16'h5A5A;
        send(2'b01, 16'h0A0A, 16'h5A5A, 1);
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (!(o_data_ready && o_data == 16'h0A0A && !o_read_done)) stable = 0;
        end
        check("offer_stable", {31'h0, stable}, 32'd1);
        step();
        i_read_enable = 1'b1; i_out_ready = 1'b0;
        wait_out_valid();
        stable = 1;
        repeat (5) begin
            @(negedge clk);
            if (!(o_out_valid && o_out_data == 16'h5A5A && !o_in_ready)) stable = 0;
        end
        check("out_stable", {31'h0, stable}, 32'd1);
        step();
        i_out_ready = 1'b1;
        @(negedge clk);

        // Reset in WAIT discards the sample
        i_data_valid = 1'b0;
        send(2'b01, 16'h7777, 16'h0000, 0);
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("rw_ctrl", {28'h0, o_in_ready, o_data_ready, o_read_done, o_out_valid}, 32'h8);
        check("rw_data", {o_data, o_out_data}, 32'd0);
        check("rw_flags", {15'h0, o_timeout_err, o_sample_count}, 32'd0);
        step();
        reset = 1'b0; i_data_valid = 1'b1; i_data_sw0 = 16'h3C3C;
        send(2'b01, 16'h7777, 16'h3C3C, 1);
        wait_out_valid();
        @(negedge clk);
        check("rw_count", {16'h0, o_sample_count}, 32'd1);

        // Count wrap from 0xFFFF
        i_data_sw0 = 16'h0F0F;
        send(2'b01, 16'h0102, 16'h0F0F, 1);
        wait_out_valid();
        force dut.r_sample_count = 16'hFFFF;
        #1;
        release dut.r_sample_count;
        @(negedge clk);
        check("count_wrap", {16'h0, o_sample_count}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
